// File: rtl/multiplicador_pkg.sv
// Shared defaults for the Q12.12 x Q1.11 -> Q1.11 fixed-point multiplier.
package multiplicador_pkg;

   localparam int unsigned DEF_W1    = 24;
   localparam int unsigned DEF_W2    = 12;
   localparam int unsigned DEF_WO    = 12;
   localparam int unsigned DEF_SHIFT = 12;

   localparam int unsigned PROD_W = DEF_W1 + DEF_W2;

   localparam logic [DEF_WO-1:0] OUT_MAX = {1'b0, {(DEF_WO-1){1'b1}}};
   localparam logic [DEF_WO-1:0] OUT_MIN = {1'b1, {(DEF_WO-1){1'b0}}};

endpackage

// File: rtl/mult_round_sat.sv
// Combinational round-half-up, arithmetic shift and clamp of a full-width product.
module mult_round_sat
   import multiplicador_pkg::*;
#(
   parameter int unsigned WP    = PROD_W,
   parameter int unsigned WO    = DEF_WO,
   parameter int unsigned SHIFT = DEF_SHIFT
) (
   input  logic signed [WP-1:0] prod,
   output logic        [WO-1:0] res,
   output logic                 sat
);

   // One guard bit so adding the rounding constant can never wrap.
   localparam logic signed [WP:0] MAXV = (WP+1)'((64'd1 << (WO-1)) - 64'd1);
   localparam logic signed [WP:0] MINV = ~MAXV;

   logic signed [WP:0] ext;
   logic signed [WP:0] half;
   logic signed [WP:0] rnd;

   always_comb begin
      ext            = {prod[WP-1], prod};
      half           = '0;
      half[SHIFT-1]  = 1'b1;
      rnd            = (ext + half) >>> SHIFT;
      res            = rnd[WO-1:0];
      sat            = 1'b0;
      if (rnd > MAXV) begin
         res = {1'b0, {(WO-1){1'b1}}};
         sat = 1'b1;
      end else if (rnd < MINV) begin
         res = {1'b1, {(WO-1){1'b0}}};
         sat = 1'b1;
      end
   end

endmodule

// File: rtl/multiplicador.sv
// Two-stage signed fixed-point multiplier: full product, then round and saturate.
module multiplicador
   import multiplicador_pkg::*;
#(
   parameter int unsigned W1    = DEF_W1,
   parameter int unsigned W2    = DEF_W2,
   parameter int unsigned WO    = DEF_WO,
   parameter int unsigned SHIFT = DEF_SHIFT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic signed [W1-1:0] in1,
   input  logic signed [W2-1:0] in2,
   output logic                 out_valid,
   output logic        [WO-1:0] out,
   output logic                 ovf
);

   localparam int unsigned WP = W1 + W2;

   logic signed [WP-1:0] p_q;
   logic                 v1_q;
   logic        [WO-1:0] res;
   logic                 sat;

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q  <= '0;
         v1_q <= 1'b0;
      end else begin
         v1_q <= in_valid;
         if (in_valid) begin
            p_q <= in1 * in2;
         end
      end
   end

   mult_round_sat #(
      .WP    (WP),
      .WO    (WO),
      .SHIFT (SHIFT)
   ) u_round_sat (
      .prod (p_q),
      .res  (res),
      .sat  (sat)
   );

   // Bubbles leave out/ovf untouched; only out_valid drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out       <= '0;
         ovf       <= 1'b0;
      end else begin
         out_valid <= v1_q;
         if (v1_q) begin
            out <= res;
            ovf <= sat;
         end
      end
   end

endmodule

// File: tb/tb_multiplicador.sv
// Directed-vector bench for multiplicador with hand-computed Q1.11 results.
module tb_multiplicador;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [23:0] in1;
   logic [11:0] in2;
   logic        out_valid;
   logic [11:0] out;
   logic        ovf;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   multiplicador dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in1       (in1),
      .in2       (in2),
      .out_valid (out_valid),
      .out       (out),
      .ovf       (ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Single transaction followed by an idle cycle with junk on the data inputs.
   task automatic run1(input string tag, input logic [23:0] a, input logic [11:0] b,
                       input logic [11:0] exp_out, input logic exp_ovf);
      @(negedge clk);
      in_valid = 1'b1;
      in1      = a;
      in2      = b;
      @(negedge clk);
      in_valid = 1'b0;
      in1      = 24'h5A5A5A;
      in2      = 12'hA5A;
      @(negedge clk);
      check({tag, " valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, " out"}, {20'd0, out}, {20'd0, exp_out});
      check({tag, " ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
      @(negedge clk);
      check({tag, " idle valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, " hold out"}, {20'd0, out}, {20'd0, exp_out});
   endtask

   logic [23:0] s_a   [6] = '{24'h001000, 24'hFFF000, 24'h000002, 24'h0B696D, 24'h123456,
                              24'h000800};
   logic [11:0] s_b   [6] = '{12'h400, 12'h400, 12'h7FF, 12'h9B3, 12'h7FF, 12'h600};
   logic        s_vin [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [11:0] s_out [6] = '{12'h400, 12'hC00, 12'h001, 12'h800, 12'h800, 12'h300};
   logic        s_ovf [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in1      = '0;
      in2      = '0;
      repeat (3) @(negedge clk);
      check("reset valid", {31'd0, out_valid}, 32'd0);
      check("reset out", {20'd0, out}, 32'd0);
      check("reset ovf", {31'd0, ovf}, 32'd0);
      rst = 1'b0;

      run1("one_x_half",   24'h001000, 12'h400, 12'h400, 1'b0);
      run1("neg_x_half",   24'hFFF000, 12'h400, 12'hC00, 1'b0);
      run1("round_down",   24'h000001, 12'h7FF, 12'h000, 1'b0);
      run1("round_up",     24'h000002, 12'h7FF, 12'h001, 1'b0);
      run1("sat_pos",      24'h0B696D, 12'h64D, 12'h7FF, 1'b1);
      run1("sat_neg",      24'h0B696D, 12'h9B3, 12'h800, 1'b1);
      run1("zero_in2",     24'h0B696D, 12'h000, 12'h000, 1'b0);
      run1("zero_in1",     24'h000000, 12'h800, 12'h000, 1'b0);
      run1("min_x_min",    24'h800000, 12'h800, 12'h7FF, 1'b1);

      // Stream: 4 valid, 1 bubble, 1 valid; results checked two clocks after drive.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            check($sformatf("stream%0d valid", i - 2), {31'd0, out_valid},
                  {31'd0, s_vin[i-2]});
            check($sformatf("stream%0d out", i - 2), {20'd0, out}, {20'd0, s_out[i-2]});
            check($sformatf("stream%0d ovf", i - 2), {31'd0, ovf}, {31'd0, s_ovf[i-2]});
         end
         if (i < 6) begin
            in_valid = s_vin[i];
            in1      = s_a[i];
            in2      = s_b[i];
         end else begin
            in_valid = 1'b0;
         end
      end

      // Reset one cycle after a valid input discards it.
      @(negedge clk);
      in_valid = 1'b1;
      in1      = 24'h001000;
      in2      = 12'h400;
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      check("rst_mid valid", {31'd0, out_valid}, 32'd0);
      check("rst_mid out", {20'd0, out}, 32'd0);
      check("rst_mid ovf", {31'd0, ovf}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst valid", {31'd0, out_valid}, 32'd0);
      check("post_rst out", {20'd0, out}, 32'd0);
      run1("after_rst",    24'hFFF000, 12'h400, 12'hC00, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
